// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : RV32I pipeline sequencing: memory freeze, load-use bubble,
//            branch squash, plus free-running event counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] ID_instr_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             EX_is_load_i,
    input  logic             EX_br_taken_i,
    input  logic             imem_read_i,
    input  logic             imem_resp_i,
    input  logic             dmem_read_i,
    input  logic             dmem_write_i,
    input  logic             dmem_resp_i,
    output logic             pc_load_o,
    output logic             IFID_load_o,
    output logic             IDEX_load_o,
    output logic             EXMEM_load_o,
    output logic             MEMWB_load_o,
    output logic             IFID_flush_o,
    output logic             IDEX_flush_o,
    output logic [width-1:0] stall_cnt_o,
    output logic [width-1:0] lu_cnt_o,
    output logic [width-1:0] flush_cnt_o
);

    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_REG   = 7'b0110011;
    localparam logic [width-1:0] c_CNT_ONE = width'(1);

    typedef enum logic {
        RUN       = 1'b0,
        MEM_STALL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_redirect_pending;
    logic             w_pending_nxt;
    logic [width-1:0] r_stall_cnt;
    logic [width-1:0] r_lu_cnt;
    logic [width-1:0] r_flush_cnt;
    logic             w_inc_stall;
    logic             w_inc_lu;
    logic             w_inc_flush;

    logic       w_rs1_used;
    logic       w_rs2_used;
    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_mem_stall;
    logic       w_lu_hazard;
    logic       w_redirect;
    logic       w_unused_instr;

    assign w_opcode = ID_instr_i[6:0];
    assign w_rs1    = ID_instr_i[19:15];
    assign w_rs2    = ID_instr_i[24:20];
    // Immediate/rd/funct bits play no part in hazard detection.
    assign w_unused_instr = ^{ID_instr_i[width-1:25], ID_instr_i[14:7]};

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            c_OP_JALR, c_OP_LOAD, c_OP_IMM: w_rs1_used = 1'b1;
            c_OP_BR, c_OP_STORE, c_OP_REG: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_mem_stall = (imem_read_i & ~imem_resp_i)
                       | ((dmem_read_i | dmem_write_i) & ~dmem_resp_i);
    assign w_lu_hazard = EX_is_load_i & (EX_rd_i != 5'd0)
                       & ((w_rs1_used & (w_rs1 == EX_rd_i))
                        | (w_rs2_used & (w_rs2 == EX_rd_i)));
    assign w_redirect  = EX_br_taken_i | r_redirect_pending;

    always_comb begin
        pc_load_o     = 1'b0;
        IFID_load_o   = 1'b0;
        IDEX_load_o   = 1'b0;
        EXMEM_load_o  = 1'b0;
        MEMWB_load_o  = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_flush_o  = 1'b0;
        w_state_nxt   = r_state;
        w_pending_nxt = r_redirect_pending;
        w_inc_stall   = 1'b0;
        w_inc_lu      = 1'b0;
        w_inc_flush   = 1'b0;
        if (rst) begin
            w_state_nxt   = RUN;
            w_pending_nxt = 1'b0;
        end else if (w_mem_stall) begin
            w_state_nxt = MEM_STALL;
            w_inc_stall = 1'b1;
            // Remember the redirect so it flushes once, after the freeze.
            if (EX_br_taken_i) w_pending_nxt = 1'b1;
        end else if (w_redirect) begin
            {pc_load_o, IFID_load_o, IDEX_load_o, EXMEM_load_o, MEMWB_load_o} = 5'b11111;
            IFID_flush_o  = 1'b1;
            IDEX_flush_o  = 1'b1;
            w_inc_flush   = 1'b1;
            w_pending_nxt = 1'b0;
            w_state_nxt   = RUN;
        end else if (w_lu_hazard) begin
            IDEX_load_o  = 1'b1;
            IDEX_flush_o = 1'b1;
            EXMEM_load_o = 1'b1;
            MEMWB_load_o = 1'b1;
            w_inc_lu     = 1'b1;
            w_state_nxt  = RUN;
        end else begin
            {pc_load_o, IFID_load_o, IDEX_load_o, EXMEM_load_o, MEMWB_load_o} = 5'b11111;
            w_state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= RUN;
            r_redirect_pending <= 1'b0;
            r_stall_cnt        <= '0;
            r_lu_cnt           <= '0;
            r_flush_cnt        <= '0;
        end else begin
            r_state            <= w_state_nxt;
            r_redirect_pending <= w_pending_nxt;
            if (w_inc_stall) r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (w_inc_lu)    r_lu_cnt    <= r_lu_cnt + c_CNT_ONE;
            if (w_inc_flush) r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign lu_cnt_o    = r_lu_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed vector table plus multi-cycle sequences for hazard_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] ID_instr_i;
    logic [4:0]  EX_rd_i;
    logic        EX_is_load_i, EX_br_taken_i;
    logic        imem_read_i, imem_resp_i;
    logic        dmem_read_i, dmem_write_i, dmem_resp_i;
    logic        pc_load_o, IFID_load_o, IDEX_load_o, EXMEM_load_o, MEMWB_load_o;
    logic        IFID_flush_o, IDEX_flush_o;
    logic [31:0] stall_cnt_o, lu_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Output bundle: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] c_RUN    = 7'b1111100;
    localparam logic [6:0] c_BUBBLE = 7'b0011101;
    localparam logic [6:0] c_SQUASH = 7'b1111111;
    localparam logic [6:0] c_FROZEN = 7'b0000000;

    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [31:0] c_ADD55 = 32'h0052_8333;

    hazard_ctrl #(.width(32)) dut (
        .clk(clk), .rst(rst),
        .ID_instr_i(ID_instr_i), .EX_rd_i(EX_rd_i),
        .EX_is_load_i(EX_is_load_i), .EX_br_taken_i(EX_br_taken_i),
        .imem_read_i(imem_read_i), .imem_resp_i(imem_resp_i),
        .dmem_read_i(dmem_read_i), .dmem_write_i(dmem_write_i),
        .dmem_resp_i(dmem_resp_i),
        .pc_load_o(pc_load_o), .IFID_load_o(IFID_load_o),
        .IDEX_load_o(IDEX_load_o), .EXMEM_load_o(EXMEM_load_o),
        .MEMWB_load_o(MEMWB_load_o),
        .IFID_flush_o(IFID_flush_o), .IDEX_flush_o(IDEX_flush_o),
        .stall_cnt_o(stall_cnt_o), .lu_cnt_o(lu_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        ld, br, ir, irs, dr, dw, drs;
        logic [6:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] outs();
        return {pc_load_o, IFID_load_o, IDEX_load_o, EXMEM_load_o, MEMWB_load_o,
                IFID_flush_o, IDEX_flush_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [4:0] rd, input logic ld,
                         input logic br, input logic ir, input logic irs, input logic dr,
                         input logic dw, input logic drs);
        ID_instr_i = instr; EX_rd_i = rd; EX_is_load_i = ld; EX_br_taken_i = br;
        imem_read_i = ir; imem_resp_i = irs;
        dmem_read_i = dr; dmem_write_i = dw; dmem_resp_i = drs;
    endtask

    task automatic idle();
        drive(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr, input logic [4:0] rd,
                           input logic ld, input logic br, input logic ir, input logic irs,
                           input logic dr, input logic dw, input logic drs, input logic [6:0] exp);
        vec_t v;
        v.name = name; v.instr = instr; v.rd = rd; v.ld = ld; v.br = br;
        v.ir = ir; v.irs = irs; v.dr = dr; v.dw = dw; v.drs = drs; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        check("reset_outs", {25'd0, outs()}, {25'd0, c_FROZEN});
        check("reset_stall_cnt", stall_cnt_o, 32'd0);
        check("reset_lu_cnt", lu_cnt_o, 32'd0);
        check("reset_flush_cnt", flush_cnt_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //      name            instr          rd  ld br ir irs dr dw drs  expected
        add_vec("nop",          c_NOP,         5,  0, 0, 0, 0,  0, 0, 0,   c_RUN);
        add_vec("lu_add",       c_ADD55,       5,  1, 0, 0, 0,  0, 0, 0,   c_BUBBLE);
        add_vec("lu_rd0",       c_ADD55,       0,  1, 0, 0, 0,  0, 0, 0,   c_RUN);
        add_vec("lui_rs1_fld",  32'h0002_8037, 5,  1, 0, 0, 0,  0, 0, 0,   c_RUN);
        add_vec("store_rs2",    32'h0050_A023, 5,  1, 0, 0, 0,  0, 0, 0,   c_BUBBLE);
        add_vec("branch_rs2",   32'h0050_8063, 5,  1, 0, 0, 0,  0, 0, 0,   c_BUBBLE);
        add_vec("imm_rs2_fld",  32'h0050_8313, 5,  1, 0, 0, 0,  0, 0, 0,   c_RUN);
        add_vec("jal_rs1_fld",  32'h0002_806F, 5,  1, 0, 0, 0,  0, 0, 0,   c_RUN);
        add_vec("jalr_rs1",     32'h0002_8067, 5,  1, 0, 0, 0,  0, 0, 0,   c_BUBBLE);
        add_vec("not_load",     c_ADD55,       5,  0, 0, 0, 0,  0, 0, 0,   c_RUN);
        add_vec("redir_over_lu",c_ADD55,       5,  1, 1, 0, 0,  0, 0, 0,   c_SQUASH);
        add_vec("imiss",        c_NOP,         0,  0, 0, 1, 0,  0, 0, 0,   c_FROZEN);
        add_vec("ihit",         c_NOP,         0,  0, 0, 1, 1,  0, 0, 0,   c_RUN);
        add_vec("dwr_miss_lu",  c_ADD55,       5,  1, 0, 0, 0,  0, 1, 0,   c_FROZEN);
        add_vec("drd_hit_lu",   c_ADD55,       5,  1, 0, 0, 0,  1, 0, 1,   c_BUBBLE);
        add_vec("i_ok_d_miss",  c_NOP,         0,  0, 0, 1, 1,  1, 0, 0,   c_FROZEN);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].rd, vecs[i].ld, vecs[i].br, vecs[i].ir,
                  vecs[i].irs, vecs[i].dr, vecs[i].dw, vecs[i].drs);
            #1;
            check(vecs[i].name, {25'd0, outs()}, {25'd0, vecs[i].exp});
        end
        @(negedge clk);
        idle();
        #1;
        check("table_stall_cnt", stall_cnt_o, 32'd3);
        check("table_lu_cnt", lu_cnt_o, 32'd5);
        check("table_flush_cnt", flush_cnt_o, 32'd1);

        // Asynchronous reset mid-cycle while a hazard is presented.
        drive(c_ADD55, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_outs", {25'd0, outs()}, {25'd0, c_FROZEN});
        check("midrst_stall_cnt", stall_cnt_o, 32'd0);
        check("midrst_lu_cnt", lu_cnt_o, 32'd0);
        check("midrst_flush_cnt", flush_cnt_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("post_rst_run", {25'd0, outs()}, {25'd0, c_RUN});

        // Load-use: one bubble, counter 0 -> 1, then load leaves ID/EX.
        do_reset();
        drive(c_ADD55, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_bubble", {25'd0, outs()}, {25'd0, c_BUBBLE});
        check("lu_cnt_before", lu_cnt_o, 32'd0);
        @(negedge clk);
        drive(c_ADD55, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_release", {25'd0, outs()}, {25'd0, c_RUN});
        check("lu_cnt_after", lu_cnt_o, 32'd1);

        // Redirect wins over a same-cycle load-use match.
        @(negedge clk);
        drive(c_ADD55, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("redir_outs", {25'd0, outs()}, {25'd0, c_SQUASH});
        @(negedge clk);
        idle();
        #1;
        check("redir_flush_cnt", flush_cnt_o, 32'd1);
        check("redir_lu_unchanged", lu_cnt_o, 32'd1);
        check("redir_no_repeat", {25'd0, outs()}, {25'd0, c_RUN});

        // I-miss: three frozen cycles, response on the fourth.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(c_NOP, 5'd0, 1'b0, 1'b0, 1'b1, (c == 3), 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("imiss_cyc%0d", c), {25'd0, outs()},
                  {25'd0, (c == 3) ? c_RUN : c_FROZEN});
            @(negedge clk);
        end
        idle();
        #1;
        check("imiss_stall_cnt", stall_cnt_o, 32'd3);

        // Branch held high across a 5-cycle D-miss: one flush on release.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(c_NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (c == 5));
            #1;
            check($sformatf("brstall_cyc%0d", c), {25'd0, outs()},
                  {25'd0, (c == 5) ? c_SQUASH : c_FROZEN});
            @(negedge clk);
        end
        idle();
        #1;
        check("brstall_single_flush", {25'd0, outs()}, {25'd0, c_RUN});
        check("brstall_flush_cnt", flush_cnt_o, 32'd1);
        check("brstall_stall_cnt", stall_cnt_o, 32'd5);

        // Branch seen only on the first stalled cycle: pending alone flushes.
        do_reset();
        drive(c_NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("pend_still_frozen", {25'd0, outs()}, {25'd0, c_FROZEN});
        @(negedge clk);
        drive(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("pend_flush", {25'd0, outs()}, {25'd0, c_SQUASH});
        @(negedge clk);
        idle();
        #1;
        check("pend_cleared", {25'd0, outs()}, {25'd0, c_RUN});

        // Counter wrap from all-ones.
        do_reset();
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        #1;
        check("wrap_preload", stall_cnt_o, 32'hFFFF_FFFF);
        drive(c_NOP, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("wrap_zero", stall_cnt_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. It watches the instruction in IF/ID, the instruction in ID/EX and both cache handshakes, and produces the per-register load enables and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It handles three events:

- freezing the whole pipeline on a cache miss;
- inserting a one-cycle bubble on a load-use hazard;
- squashing the two younger stages on a taken branch or jump resolved in EX.

It also keeps free-running performance counters.

## Interface

Parameters
- `width`, default 32: instruction and counter width.

Ports
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `ID_instr_i` in `width`: instruction currently in IF/ID.
- `EX_rd_i` in 5: destination register of the instruction in ID/EX.
- `EX_is_load_i` in 1: the instruction in ID/EX is a load (opcode 0000011).
- `EX_br_taken_i` in 1: the branch, JAL or JALR in EX redirects the PC this cycle.
- `imem_read_i` in 1: I-cache request outstanding.
- `imem_resp_i` in 1: I-cache response this cycle.
- `dmem_read_i` in 1: D-cache read outstanding.
- `dmem_write_i` in 1: D-cache write outstanding.
- `dmem_resp_i` in 1: D-cache response this cycle.
- `pc_load_o` out 1: PC register load enable.
- `IFID_load_o` out 1: IF/ID load enable.
- `IDEX_load_o` out 1: ID/EX load enable.
- `EXMEM_load_o` out 1: EX/MEM load enable.
- `MEMWB_load_o` out 1: MEM/WB load enable.
- `IFID_flush_o` out 1: when loaded, IF/ID takes a NOP (0x00000013) instead of its input.
- `IDEX_flush_o` out 1: when loaded, ID/EX takes an all-zero control word (bubble).
- `stall_cnt_o` out `width`: cycles spent frozen on memory.
- `lu_cnt_o` out `width`: load-use bubbles inserted.
- `flush_cnt_o` out `width`: redirects taken.

## Operation

Source decode of `ID_instr_i[6:0]`:
- `rs1` is used by JALR 1100111, BR 1100011, LOAD 0000011, STORE 0100011, IMM 0010011 and REG 0110011.
- `rs2` is used by BR, STORE and REG.
- LUI, AUIPC, JAL and all other opcodes use neither source.
- `rs1` = `[19:15]`, `rs2` = `[24:20]`.

Derived terms:
- `mem_stall` = (`imem_read_i` & ~`imem_resp_i`) | ((`dmem_read_i` | `dmem_write_i`) & ~`dmem_resp_i`).
- `lu_hazard` = `EX_is_load_i` & (`EX_rd_i` != 0) & ((rs1 used & rs1 == `EX_rd_i`) | (rs2 used & rs2 == `EX_rd_i`)).
- `redirect` = `EX_br_taken_i` | `redirect_pending`.

State:
- FSM state: RUN or MEM_STALL.
- 1-bit `redirect_pending`.
- Three counters.

Cases are evaluated in strict priority order, one case per cycle.
1. `rst` high: state RUN, `redirect_pending` 0, all counters 0. All load and flush outputs are 0.
2. `mem_stall`:
   - All five loads 0, both flushes 0.
   - Next state MEM_STALL.
   - `stall_cnt_o` += 1.
   - If `EX_br_taken_i`, set `redirect_pending`.
3. `redirect` (not stalled):
   - All five loads 1.
   - `IFID_flush_o` = 1, `IDEX_flush_o` = 1.
   - `flush_cnt_o` += 1.
   - Clear `redirect_pending`. Next state RUN.
   - A load-use hazard in the same cycle is ignored because the ID instruction is wrong-path.
4. `lu_hazard`:
   - `pc_load_o` = 0, `IFID_load_o` = 0.
   - `IDEX_load_o` = 1 with `IDEX_flush_o` = 1.
   - `EXMEM_load_o` = 1, `MEMWB_load_o` = 1.
   - `lu_cnt_o` += 1.
5. Otherwise all loads 1, flushes 0. Next state RUN.

Additional rules:
- A redirect seen during a stall produces exactly one flush, on the first unstalled cycle, even if `EX_br_taken_i` stays high for the whole stall.
- Counters are `width` bits and wrap from all-ones to 0 without saturating.
- x0 never causes a hazard.
- Store `rs2` and branch `rs2` matches count as hazards.

## Timing

- Load, flush and hazard outputs are combinational from the current inputs and `redirect_pending`, valid in the same cycle. The pipeline registers sample them at the next rising edge.
- The counter outputs are registered.
- Load-use costs exactly one bubble cycle. On the following cycle the load has left ID/EX, so `lu_hazard` falls naturally.
- Memory stall length equals the number of cycles without a response. The pipeline resumes on the cycle the response is present (`resp` high means not stalled).
- Simultaneous I-miss and D-miss: frozen until both responses have arrived. Each stalled cycle counts once.
- If reset asserts mid-stall, outputs drop to 0 immediately, and the pending redirect and counters are cleared asynchronously.

## Test plan

- **Reset:** assert `rst` mid-run with counters nonzero. Required: all outputs 0 immediately; after release with no hazards, all five loads are 1 and flushes are 0.
- **Load-use:** `EX_is_load_i`=1, `EX_rd_i`=5, `ID_instr_i`=0x00528333 (add x6,x5,x5). Required: for exactly one cycle `pc_load_o`=0, `IFID_load_o`=0, `IDEX_flush_o`=1; `lu_cnt_o` goes 0→1. The same test with rd=0, or with LUI in ID, must not stall.
- **Redirect:** `EX_br_taken_i`=1 together with a load-use match. Required: all loads 1, both flushes 1, `flush_cnt_o`+1, `lu_cnt_o` unchanged.
- **I-miss:** `imem_read_i`=1 for 4 cycles with `imem_resp_i` rising on the 4th. Required: 3 frozen cycles, `stall_cnt_o`=3, and normal loads on the 4th cycle.
- **Branch under stall:** `EX_br_taken_i`=1 during a 5-cycle D-miss. Required: no flush while stalled, exactly one flush pulse on release, `flush_cnt_o`=1.
- **Counter wrap:** preload `stall_cnt_o` to 0xFFFFFFFF via a bench force, then one stall cycle. Required: `stall_cnt_o` reads 0x00000000.
